// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store controller placed in front of a
// byte-addressed data memory that has a one-cycle registered read.
//
// Stores go into a small FIFO store buffer and drain to memory one per cycle
// whenever the memory port is not being used for a load. Each load is
// sequenced through the registered read, and its result goes to writeback as
// a one-cycle pulse. There is no store-to-load forwarding. A load that
// touches any byte of a buffered store waits until the buffer is empty.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_*               request from the EX/MEM register (valid/ready)
//   resp_*              load result to writeback (resp_valid is a pulse)
//   mem*                data memory port (write, read, format, addr, data)
//   sb_count            store-buffer occupancy
//   dbg_state           current FSM state (IDLE=0, LD_HOLD=1, RD_ISSUE=2, RD_DATA=3)
//
// Handshake: a request transfers on a rising clk edge where
// req_valid && req_ready are both high. The requester holds all req_* fields
// stable while req_valid is high and req_ready is low. req_ready may depend
// combinationally on req_valid/req_write (store refused when the buffer is full).
module mem_access_unit #(
    parameter int SB_DEPTH = 2,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [1:0]                req_size,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [TAG_W-1:0]          req_tag,
    output logic                      resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic [TAG_W-1:0]          resp_tag,
    output logic                      memWrEnable,
    output logic                      memRdEnable,
    output logic [1:0]                memNumberOfByte,
    output logic [ADDR_W-1:0]         memAddress,
    output logic [DATA_W-1:0]         memIn,
    input  logic [DATA_W-1:0]         memOut,
    output logic [$clog2(SB_DEPTH):0] sb_count,
    output logic [1:0]                dbg_state
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_HOLD  = 2'd1,
        RD_ISSUE = 2'd2,
        RD_DATA  = 2'd3
    } state_t;

    state_t state, next_state;

    // Store buffer
    logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
    logic [DATA_W-1:0] sb_data [SB_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;

    // Latched load
    logic [ADDR_W-1:0] ld_addr;
    logic [1:0]        ld_size;
    logic [TAG_W-1:0]  ld_tag;

    // Last driven memory-port values, so they hold while the port is unused
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_in_q;
    logic [1:0]        mem_nob_q;

    logic              push, pop, load_accept, hazard, req_wide;
    logic [1:0]        req_size_m;
    logic [PTR_W-1:0]  hz_idx;
    logic [ADDR_W-1:0] hz_a, hz_a1, req_a1;

    assign full       = (count == CNT_W'(SB_DEPTH));
    assign req_size_m = (req_size == 2'b11) ? 2'b00 : req_size;
    assign req_wide   = (req_size_m == 2'b00);
    assign req_a1     = req_addr + ADDR_W'(1);
    assign sb_count   = count;
    assign dbg_state  = state;

    // Overlap check against every valid entry, including a head that is
    // popping this cycle. A store covers A and A+1; a load covers L, plus
    // L+1 when wide. All additions wrap at the address width.
    always_comb begin
        hazard = 1'b0;
        hz_idx = '0;
        hz_a   = '0;
        hz_a1  = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            hz_idx = rd_ptr + PTR_W'(i);
            hz_a   = sb_addr[hz_idx];
            hz_a1  = hz_a + ADDR_W'(1);
            if (i < int'(count)) begin
                if ((req_addr == hz_a) || (req_addr == hz_a1) ||
                    (req_wide && (req_a1 == hz_a)))
                    hazard = 1'b1;
            end
        end
    end

    always_comb begin
        next_state      = state;
        req_ready       = 1'b0;
        push            = 1'b0;
        pop             = 1'b0;
        load_accept     = 1'b0;
        memWrEnable     = 1'b0;
        memRdEnable     = 1'b0;
        memAddress      = mem_addr_q;
        memIn           = mem_in_q;
        memNumberOfByte = mem_nob_q;
        resp_valid      = 1'b0;
        resp_data       = '0;
        resp_tag        = '0;

        // The buffer drains whenever the port is not carrying a read.
        if (state != RD_ISSUE && count != '0) begin
            pop         = 1'b1;
            memWrEnable = 1'b1;
            memAddress  = sb_addr[rd_ptr];
            memIn       = sb_data[rd_ptr];
        end

        case (state)
            IDLE: begin
                // Held low during reset; the full check uses the registered
                // count only, so a same-cycle pop does not admit a store.
                req_ready = rst_n && !(req_valid && req_write && full);
                if (req_valid && req_ready) begin
                    if (req_write) begin
                        push = 1'b1;
                    end else begin
                        load_accept = 1'b1;
                        next_state  = hazard ? LD_HOLD : RD_ISSUE;
                    end
                end
            end
            LD_HOLD: begin
                if (count == '0) next_state = RD_ISSUE;
            end
            RD_ISSUE: begin
                memRdEnable     = 1'b1;
                memAddress      = ld_addr;
                memNumberOfByte = ld_size;
                next_state      = RD_DATA;
            end
            RD_DATA: begin
                resp_valid = 1'b1;
                resp_data  = memOut;
                resp_tag   = ld_tag;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ld_addr    <= '0;
            ld_size    <= '0;
            ld_tag     <= '0;
            mem_addr_q <= '0;
            mem_in_q   <= '0;
            mem_nob_q  <= '0;
        end else begin
            state      <= next_state;
            mem_addr_q <= memAddress;
            mem_in_q   <= memIn;
            mem_nob_q  <= memNumberOfByte;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
            if (load_accept) begin
                ld_addr <= req_addr;
                ld_size <= req_size_m;
                ld_tag  <= req_tag;
            end
        end
    end

    // Buffer storage carries no reset; validity comes from count/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[wr_ptr] <= req_addr;
            sb_data[wr_ptr] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int SB_DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_tag = '0;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic [2:0]  resp_tag;
  logic        memWrEnable, memRdEnable;
  logic [1:0]  memNumberOfByte;
  logic [15:0] memAddress, memIn;
  logic [15:0] memOut = '0;
  logic [1:0]  sb_count;
  logic [1:0]  dbg_state;

  mem_access_unit #(.SB_DEPTH(SB_DEPTH), .ADDR_W(16), .DATA_W(16), .TAG_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag),
    .memWrEnable(memWrEnable), .memRdEnable(memRdEnable),
    .memNumberOfByte(memNumberOfByte), .memAddress(memAddress), .memIn(memIn),
    .memOut(memOut), .sb_count(sb_count), .dbg_state(dbg_state)
  );

  // ---------------- memory device and reference memory ----------------
  logic [7:0] dev_mem [0:65535];
  logic [7:0] ref_mem [0:65535];

  function automatic logic [15:0] fmt(input logic [7:0] lo, input logic [7:0] hi,
                                      input logic [1:0] sz);
    case (sz)
      2'b01:   return {8'h00, lo};
      2'b10:   return {{8{lo[7]}}, lo};
      default: return {hi, lo};
    endcase
  endfunction

  always @(posedge clk) begin
    if (memWrEnable) begin
      dev_mem[memAddress]         <= memIn[7:0];
      dev_mem[memAddress + 16'd1] <= memIn[15:8];
    end
    if (memRdEnable)
      memOut <= fmt(dev_mem[memAddress], dev_mem[memAddress + 16'd1], memNumberOfByte);
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [18:0] exp_q[$];      // {tag, data} of each accepted load
  int          exp_cyc_q[$];  // cycle in which its resp_valid must be seen
  logic [17:0] exp_rd_q[$];   // {addr, format} expected on the read port
  logic [31:0] exp_wr_q[$];   // {addr, data} expected on the write port
  logic [15:0] st_list[$];    // addresses of all accepted stores, in order
  int          wr_done = 0;   // stores seen written so far
  bit          wr_this = 1'b0;// a write was seen in the latest cycle
  bit          busy = 1'b0;   // a load is in flight

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit overlaps(input logic [15:0] st, input logic [15:0] ld, input bit wide);
    logic [15:0] sb [2];
    logic [15:0] lb [2];
    sb[0] = st; sb[1] = st + 16'd1;
    lb[0] = ld; lb[1] = ld + 16'd1;
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < (wide ? 2 : 1); l++)
        if (sb[s] == lb[l]) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ready", {31'd0, req_ready}, 32'd0);
      check("rst_ctrl", {27'd0, resp_valid, memWrEnable, memRdEnable, sb_count}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
      check("rst_addr_in", {memAddress, memIn}, 32'd0);
      check("rst_resp", {11'd0, memNumberOfByte, resp_tag, resp_data}, 32'd0);
    end else begin
      int occ;
      occ = st_list.size() - wr_done;
      check("sb_count", {30'd0, sb_count}, 32'(occ));
      check("rw_exclusive", {31'd0, memRdEnable & memWrEnable}, 32'd0);
      if (req_valid)
        check("req_ready", {31'd0, req_ready},
              {31'd0, !busy && !(req_write && occ == SB_DEPTH)});
      if (occ > 0 && !memRdEnable)
        check("drain_active", {31'd0, memWrEnable}, 32'd1);
      wr_this = 1'b0;
      if (memWrEnable) begin
        if (exp_wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else check("wr_addr_data", {memAddress, memIn}, exp_wr_q.pop_front());
        wr_done++;
        wr_this = 1'b1;
      end
      if (memRdEnable) begin
        if (exp_rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
        else check("rd_addr_fmt", {14'd0, memAddress, memNumberOfByte}, {14'd0, exp_rd_q.pop_front()});
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
        else begin
          check("resp_tag_data", {13'd0, resp_tag, resp_data}, {13'd0, exp_q.pop_front()});
          check("resp_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        end
        busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input bit wr, input logic [1:0] sz, input logic [15:0] a,
                       input logic [15:0] d, input logic [2:0] t);
    bit acc;
    int base, k;
    bit haz, wide;
    req_valid = 1'b1; req_write = wr; req_size = sz;
    req_addr = a; req_wdata = d; req_tag = t;
    acc = 1'b0;
    for (int w = 0; w < 64 && !acc; w++) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!acc) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    if (wr) begin
      ref_mem[a]         = d[7:0];
      ref_mem[a + 16'd1] = d[15:8];
      st_list.push_back(a);
      exp_wr_q.push_back({a, d});
    end else begin
      // Stores still buffered at the acceptance edge, including one whose
      // write was seen in the cycle just ended.
      base = wr_done - (wr_this ? 1 : 0);
      k    = st_list.size() - base;
      wide = (sz == 2'b00) || (sz == 2'b11);
      haz  = 1'b0;
      for (int i = base; i < st_list.size(); i++)
        if (overlaps(st_list[i], a, wide)) haz = 1'b1;
      exp_q.push_back({t, fmt(ref_mem[a], ref_mem[a + 16'd1], sz)});
      exp_cyc_q.push_back(cyc + (haz ? k + 1 : 1));
      exp_rd_q.push_back({a, (sz == 2'b11) ? 2'b00 : sz});
      busy = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete(); exp_cyc_q.delete(); exp_rd_q.delete();
    exp_wr_q.delete(); st_list.delete();
    wr_done = 0; wr_this = 1'b0; busy = 1'b0;
    req_valid = 1'b0;
    // Buffered stores are discarded: the reference follows the device.
    for (int i = 0; i < 65536; i++) ref_mem[i] = dev_mem[i];
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 65536; i++) begin
      dev_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
      ref_mem[i] = dev_mem[i];
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // store then independent wide load
    issue(1'b1, 2'b00, 16'h0010, 16'hBEEF, 3'd0);
    issue(1'b0, 2'b00, 16'h0020, 16'h0000, 3'd3);
    idle(3);
    // overlapping byte loads: sign- and zero-extended
    issue(1'b1, 2'b00, 16'h0040, 16'h8012, 3'd0);
    issue(1'b0, 2'b10, 16'h0041, 16'h0000, 3'd5);
    issue(1'b0, 2'b01, 16'h0041, 16'h0000, 3'd6);
    idle(2);
    // overlap through address wrap
    issue(1'b1, 2'b00, 16'hFFFF, 16'h1234, 3'd0);
    issue(1'b0, 2'b01, 16'h0000, 16'h0000, 3'd1);
    // format 11 drives 00 on the read port
    issue(1'b0, 2'b11, 16'h0004, 16'h0000, 3'd2);
    // stores queued behind a load, written in order
    issue(1'b0, 2'b00, 16'h0060, 16'h0000, 3'd7);
    issue(1'b1, 2'b00, 16'h0070, 16'h1111, 3'd0);
    issue(1'b1, 2'b00, 16'h0072, 16'h2222, 3'd0);
    issue(1'b1, 2'b00, 16'h0074, 16'h3333, 3'd0);
    issue(1'b0, 2'b00, 16'h0073, 16'h0000, 3'd4);
    idle(3);

    // randomized traffic concentrated on a few addresses and the wrap point
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      if ($urandom_range(0, 3) == 0) a = 16'hFFFE + 16'($urandom_range(0, 3));
      else a = 16'h0020 + 16'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a,
            16'($urandom), 3'($urandom_range(0, 7)));
    end
    idle(4);

    // reset while a load sits in RD_ISSUE
    issue(1'b1, 2'b00, 16'h0200, 16'hCAFE, 3'd0);
    issue(1'b0, 2'b00, 16'h0300, 16'h0000, 3'd4);
    #3;
    do_reset();
    idle(5);
    // reset while a store is still buffered: the store must be lost
    issue(1'b1, 2'b00, 16'h0500, 16'hAAAA, 3'd0);
    #3;
    do_reset();
    idle(3);
    issue(1'b0, 2'b00, 16'h0500, 16'h0000, 3'd1);

    // drain and report
    for (int w = 0; w < 200 && (exp_q.size() != 0 || exp_wr_q.size() != 0); w++) idle(1);
    idle(2);
    check("leftover_resp", 32'(exp_q.size()), 32'd0);
    check("leftover_wr", 32'(exp_wr_q.size()), 32'd0);
    check("leftover_rd", 32'(exp_rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
